pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
Sits on the consumer side of the 50 MHz→100 MHz PLL and drives the PLL's rst input. It sequences PLL reset, waits for lock with timeout and retry, and qualifies lock stability before releasing the SD_CARD system reset. It also detects loss of lock in operation, re-initialises the PLL, and reports status and a relock counter to software-visible logic. The block runs entirely in the refclk (50 MHz) domain.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt
LOCK_TIMEOUT, 50000, max cycles in WAIT_LOCK before retry (1 ms at 50 MHz)
SETTLE_CYCLES, 1024, consecutive synced-locked cycles required before release
UNLOCK_FILTER, 4, consecutive synced-unlocked cycles in RUN that count as lock loss
MAX_RETRIES, 3, total failed lock attempts before FAULT
CNT_W, 16, shared counter width; must hold max(all cycle params)

Ports:
clk  in  1  reference clock, same net as PLL refclk
reset_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked output, asynchronous to clk
pll_rst  out  1  PLL reset, active-high
sys_reset_n  out  1  downstream reset, active-low
fault  out  1  sticky: lock never achieved within MAX_RETRIES
state  out  3  0=RST_PLL 1=WAIT_LOCK 2=SETTLE 3=RUN 4=FAULT
relock_count  out  8  RUN→RST_PLL transitions, saturating

Behaviour:
- Reset (reset_n=0, async): state=RST_PLL, pll_rst=1, sys_reset_n=0 (asserted asynchronously), fault=0, relock_count=0, retry counter=0, cycle counter=0, synchroniser flops=0.
- pll_locked passes through a 2-FF synchroniser to locked_s. All decisions use locked_s. An edge on pll_locked at sample cycle T is visible as locked_s at T+2.
- All outputs are registered and decoded from state: pll_rst=1 in RST_PLL and FAULT; sys_reset_n=1 only in RUN; fault=1 only in FAULT.
- RST_PLL: counter counts 0..PLL_RST_CYCLES-1, then WAIT_LOCK with counter cleared.
- WAIT_LOCK: if locked_s=1, go to SETTLE with counter cleared. Otherwise, when the counter reaches LOCK_TIMEOUT-1, increment retry. If the new retry equals MAX_RETRIES, go to FAULT; else go to RST_PLL. If locked_s and the timeout coincide, lock wins.
- SETTLE: counter counts cycles with locked_s=1. Any locked_s=0 goes to WAIT_LOCK with counter cleared; the timeout restarts and retry is unchanged. Counter reaching SETTLE_CYCLES-1 with locked_s=1 goes to RUN and clears retry.
- Release latency: pll_locked rising at sample cycle T (stable) gives sys_reset_n=1 at cycle T+3+SETTLE_CYCLES.
- RUN: counter counts consecutive locked_s=0 cycles and clears on any locked_s=1. Reaching UNLOCK_FILTER:
  - go to RST_PLL;
  - sys_reset_n=0 on the same edge the state changes;
  - relock_count+1, saturating at 255.
  Glitches shorter than UNLOCK_FILTER cycles are ignored.
- FAULT: terminal until reset_n. pll_rst=1, sys_reset_n=0, pll_locked ignored.
- sys_reset_n deasserts synchronously to clk only. It asserts asynchronously on reset_n and synchronously on lock loss.
- Counter compares use ==, never >=. The counter cannot wrap within any state for legal parameters.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, UNLOCK_FILTER=3, MAX_RETRIES=2; cycle 0 = first edge after reset_n rises.
1. Normal bring-up: pll_locked held high from cycle 10 → pll_rst=1 cycles 0–3 and 0 from cycle 4; state=SETTLE at 13; sys_reset_n=1 and state=3 at cycle 21; fault=0; relock_count=0.
2. Never locks: pll_locked=0 throughout → two pll_rst pulses of 4 cycles each; state=4 and fault=1 at cycle 48; pll_rst=1 and sys_reset_n=0 thereafter; pulsing pll_locked afterwards has no effect.
3. RUN glitch filter: after scenario 1, drop pll_locked for 2 cycles → sys_reset_n stays 1, relock_count=0. Then drop it for 3+ cycles → sys_reset_n=0 and state=0 5 cycles after the drop (2 sync + 3 filter); relock_count=1; a 4-cycle pll_rst pulse follows; re-release after relock.
4. Drop during SETTLE: pll_locked high 5 cycles then low → state returns to WAIT_LOCK; sys_reset_n never rises; timeout restarts from 0; retry unchanged (lock on the next attempt still succeeds).
5. Async reset mid-RUN: assert reset_n between clock edges → sys_reset_n=0 and pll_rst=1 immediately, without a clock; relock_count and fault cleared; bring-up repeats as in scenario 1.
6. Saturation: force 260 lock-loss events → relock_count=255 and holds; state machine still recovers each time.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL/reset consumers.
// The master side is the supervisor itself.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       fault;
    logic [2:0] state;
    logic [7:0] relock_count;

    modport master (
        input  pll_locked,
        output pll_rst, sys_reset_n, fault, state, relock_count
    );

    modport slave (
        output pll_locked,
        input  pll_rst, sys_reset_n, fault, state, relock_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier: drives pll_rst, waits for lock with
// timeout/retry, qualifies stability, and releases sys_reset_n. refclk domain only.
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned UNLOCK_FILTER  = 4,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pll_lock_supervisor_if.master sup
);
    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int unsigned RTY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNL_LAST = CNT_W'(UNLOCK_FILTER - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic [1:0]       sync_q;
    logic             locked_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
    logic [7:0]       relock_q, relock_d;
    logic             pll_rst_q, sys_reset_n_q, fault_q;

    assign locked_s  = sync_q[1];
    assign retry_inc = retry_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        retry_d  = retry_q;
        relock_d = relock_q;
        case (state_q)
            RST_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coinciding timeout.
                if (locked_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    state_d = (retry_inc == RTY_MAX) ? FAULT : RST_PLL;
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SET_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == UNL_LAST) begin
                    state_d = RST_PLL;
                    cnt_d   = '0;
                    if (relock_q != '1) relock_d = relock_q + 1'b1;
                end
            end
            FAULT: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = RST_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            state_q       <= RST_PLL;
            cnt_q         <= '0;
            retry_q       <= '0;
            relock_q      <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], sup.pll_locked};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            relock_q      <= relock_d;
            pll_rst_q     <= (state_d == RST_PLL) || (state_d == FAULT);
            sys_reset_n_q <= (state_d == RUN);
            fault_q       <= (state_d == FAULT);
        end
    end

    assign sup.pll_rst      = pll_rst_q;
    assign sup.sys_reset_n  = sys_reset_n_q;
    assign sup.fault        = fault_q;
    assign sup.state        = state_q;
    assign sup.relock_count = relock_q;
endmodule
